// File: rtl/lsu_bus_router.sv
// rtl/lsu_bus_router.sv - LSQ router to dcache or Wishbone uncached windows; optional bus timeout via LSU_BUS_TIMEOUT_EN
module lsu_bus_router #(
  parameter int XLEN               = 64,
  parameter int VIRTUAL_ADDR_LEN   = 39,
  parameter int LSU_LSQ_SIZE_WIDTH = 4,
  parameter int WB_DATA_LEN        = 32,
  parameter int N_REGIONS          = 2,
  parameter logic [N_REGIONS*VIRTUAL_ADDR_LEN-1:0] REGION_BASE  = {39'h0040000000, 39'h0010000000},
  parameter logic [N_REGIONS*VIRTUAL_ADDR_LEN-1:0] REGION_LIMIT = {39'h0040001000, 39'h0020000000},
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,
  input  logic                          lsq_req_valid_i,
  output logic                          lsq_req_ready_o,
  input  logic                          lsq_req_opcode_i,
  input  logic                          lsq_req_sign_i,
  input  logic [1:0]                    lsq_req_size_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]   lsq_req_addr_i,
  input  logic [XLEN-1:0]               lsq_req_data_i,
  input  logic [LSU_LSQ_SIZE_WIDTH-1:0] lsq_req_lsq_index_i,
  output logic                          lsq_resp_valid_o,
  input  logic                          lsq_resp_ready_i,
  output logic [LSU_LSQ_SIZE_WIDTH-1:0] lsq_resp_lsq_index_o,
  output logic [XLEN-1:0]               lsq_resp_data_o,
  output logic                          lsq_resp_err_o,
  output logic                          dcache_req_valid_o,
  input  logic                          dcache_req_ready_i,
  output logic                          dcache_req_opcode_o,
  output logic                          dcache_req_sign_o,
  output logic [1:0]                    dcache_req_size_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]   dcache_req_addr_o,
  output logic [XLEN-1:0]               dcache_req_data_o,
  output logic [LSU_LSQ_SIZE_WIDTH-1:0] dcache_req_lsq_index_o,
  input  logic                          dcache_resp_valid_i,
  input  logic [LSU_LSQ_SIZE_WIDTH-1:0] dcache_resp_lsq_index_i,
  input  logic [XLEN-1:0]               dcache_resp_data_i,
  output logic                          dcache_resp_ready_o,
  output logic                          wb_cyc_o,
  output logic                          wb_stb_o,
  output logic                          wb_we_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]   wb_adr_o,
  output logic [WB_DATA_LEN-1:0]        wb_dat_o,
  output logic [3:0]                    wb_sel_o,
  input  logic                          wb_ack_i,
  input  logic                          wb_err_i,
  input  logic [WB_DATA_LEN-1:0]        wb_dat_i
);
  localparam int AW = VIRTUAL_ADDR_LEN;
  localparam int DW = WB_DATA_LEN;

  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, RESP, DRAIN} state_t;
  state_t state, state_nxt;

  logic                          op, sign, resp_err, hit, accept, bus_done, timeout;
  logic [1:0]                    size;
  logic [AW-1:0]                 addr;
  logic [DW-1:0]                 data_hi, lo_word;
  logic [LSU_LSQ_SIZE_WIDTH-1:0] index;
  logic [XLEN-1:0]               resp_data;

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return |a[2:0];
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [DW-1:0] w, input logic [1:0] sz,
                                               input logic sgn);
    case (sz)
      2'd0:    return {{(XLEN-8){sgn & w[7]}}, w[7:0]};
      2'd1:    return {{(XLEN-16){sgn & w[15]}}, w[15:0]};
      default: return {{(XLEN-32){sgn & w[31]}}, w[31:0]};
    endcase
  endfunction

  // Uncached window decode on the incoming request address
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (lsq_req_addr_i >= REGION_BASE[i*AW +: AW] && lsq_req_addr_i < REGION_LIMIT[i*AW +: AW])
        hit = 1'b1;
    end
  end

  assign accept   = (state == IDLE) && hit && lsq_req_valid_i && !flush;
  assign bus_done = wb_ack_i || wb_err_i;

  assign dcache_req_valid_o     = lsq_req_valid_i && !hit;
  assign dcache_req_opcode_o    = lsq_req_opcode_i;
  assign dcache_req_sign_o      = lsq_req_sign_i;
  assign dcache_req_size_o      = lsq_req_size_i;
  assign dcache_req_addr_o      = lsq_req_addr_i;
  assign dcache_req_data_o      = lsq_req_data_i;
  assign dcache_req_lsq_index_o = lsq_req_lsq_index_i;
  assign lsq_req_ready_o        = hit ? (state == IDLE) : dcache_req_ready_i;

  // A pending bus response wins over the dcache response path
  assign dcache_resp_ready_o  = (state != RESP) && lsq_resp_ready_i;
  assign lsq_resp_valid_o     = (state == RESP) ? 1'b1 : dcache_resp_valid_i;
  assign lsq_resp_lsq_index_o = (state == RESP) ? index : dcache_resp_lsq_index_i;
  assign lsq_resp_data_o      = (state == RESP) ? resp_data : dcache_resp_data_i;
  assign lsq_resp_err_o       = (state == RESP) && resp_err;
  assign wb_stb_o             = wb_cyc_o;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] cnt;
  assign timeout = (cnt == TW'(TIMEOUT_CYCLES - 1)) && !bus_done;

  // Ack wait counter, restarted whenever a new bus wait state is entered
  always_ff @(posedge clk) begin
    if (!rstn) cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else if (!wb_ack_i) cnt <= cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state decode; flush beats ack/err, err beats ack
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (accept) state_nxt = misaligned(lsq_req_size_i, lsq_req_addr_i[2:0]) ? RESP : BEAT0;
      BEAT0, BEAT1:
        if (flush) state_nxt = bus_done ? IDLE : DRAIN;
        else if (wb_err_i) state_nxt = RESP;
        else if (wb_ack_i) begin
          if (state == BEAT0 && size == 2'd3) state_nxt = BEAT1;
          else state_nxt = op ? IDLE : RESP;
        end
        else if (timeout) state_nxt = RESP;
      RESP:
        if (flush || lsq_resp_ready_i) state_nxt = IDLE;
      DRAIN:
        if (bus_done || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched request, response capture and registered Wishbone outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      op        <= 1'b0;
      sign      <= 1'b0;
      size      <= '0;
      addr      <= '0;
      data_hi   <= '0;
      index     <= '0;
      lo_word   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op        <= lsq_req_opcode_i;
        sign      <= lsq_req_sign_i;
        size      <= lsq_req_size_i;
        addr      <= lsq_req_addr_i;
        data_hi   <= lsq_req_data_i[2*DW-1:DW];
        index     <= lsq_req_lsq_index_i;
        resp_data <= '0;
        resp_err  <= misaligned(lsq_req_size_i, lsq_req_addr_i[2:0]);
      end
      if (state == BEAT0 && state_nxt == BEAT1) lo_word <= wb_dat_i;
      if ((state == BEAT0 || state == BEAT1) && state_nxt == RESP) begin
        if (wb_err_i || timeout) begin
          resp_err  <= 1'b1;
          resp_data <= '0;
        end else begin
          resp_err  <= 1'b0;
          resp_data <= (size == 2'd3) ? {wb_dat_i, lo_word}
                                      : load_ext(wb_dat_i >> {addr[1:0], 3'b000}, size, sign);
        end
      end
      case (state_nxt)
        BEAT0:
          if (state == IDLE) begin
            wb_cyc_o <= 1'b1;
            wb_we_o  <= lsq_req_opcode_i;
            wb_adr_o <= {lsq_req_addr_i[AW-1:2], 2'b00};
            wb_dat_o <= lsq_req_data_i[DW-1:0] << {lsq_req_addr_i[1:0], 3'b000};
            case (lsq_req_size_i)
              2'd0:    wb_sel_o <= 4'b0001 << lsq_req_addr_i[1:0];
              2'd1:    wb_sel_o <= 4'b0011 << lsq_req_addr_i[1:0];
              default: wb_sel_o <= 4'hf;
            endcase
          end
        BEAT1:
          if (state == BEAT0) begin
            wb_adr_o <= addr + AW'(4);
            wb_dat_o <= data_hi;
          end
        DRAIN: ;
        default: begin
          wb_cyc_o <= 1'b0;
          wb_we_o  <= 1'b0;
          wb_adr_o <= '0;
          wb_dat_o <= '0;
          wb_sel_o <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_bus_router.sv
// tb/tb_lsu_bus_router.sv - bench for lsu_bus_router; timeout sequence active with LSU_BUS_TIMEOUT_EN
module tb_lsu_bus_router;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        lsq_req_valid_i = 1'b0, lsq_req_ready_o, lsq_req_opcode_i = 1'b0, lsq_req_sign_i = 1'b0;
  logic [1:0]  lsq_req_size_i = '0;
  logic [38:0] lsq_req_addr_i = '0;
  logic [63:0] lsq_req_data_i = '0;
  logic [3:0]  lsq_req_lsq_index_i = '0;
  logic        lsq_resp_valid_o, lsq_resp_ready_i = 1'b0, lsq_resp_err_o;
  logic [3:0]  lsq_resp_lsq_index_o;
  logic [63:0] lsq_resp_data_o;
  logic        dcache_req_valid_o, dcache_req_ready_i = 1'b0, dcache_req_opcode_o, dcache_req_sign_o;
  logic [1:0]  dcache_req_size_o;
  logic [38:0] dcache_req_addr_o;
  logic [63:0] dcache_req_data_o;
  logic [3:0]  dcache_req_lsq_index_o;
  logic        dcache_resp_valid_i = 1'b0, dcache_resp_ready_o;
  logic [3:0]  dcache_resp_lsq_index_i = '0;
  logic [63:0] dcache_resp_data_i = '0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [38:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic [31:0] wb_dat_i = '0;

  always #5 clk = ~clk;

  lsu_bus_router #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .lsq_req_valid_i(lsq_req_valid_i), .lsq_req_ready_o(lsq_req_ready_o),
    .lsq_req_opcode_i(lsq_req_opcode_i), .lsq_req_sign_i(lsq_req_sign_i),
    .lsq_req_size_i(lsq_req_size_i), .lsq_req_addr_i(lsq_req_addr_i),
    .lsq_req_data_i(lsq_req_data_i), .lsq_req_lsq_index_i(lsq_req_lsq_index_i),
    .lsq_resp_valid_o(lsq_resp_valid_o), .lsq_resp_ready_i(lsq_resp_ready_i),
    .lsq_resp_lsq_index_o(lsq_resp_lsq_index_o), .lsq_resp_data_o(lsq_resp_data_o),
    .lsq_resp_err_o(lsq_resp_err_o),
    .dcache_req_valid_o(dcache_req_valid_o), .dcache_req_ready_i(dcache_req_ready_i),
    .dcache_req_opcode_o(dcache_req_opcode_o), .dcache_req_sign_o(dcache_req_sign_o),
    .dcache_req_size_o(dcache_req_size_o), .dcache_req_addr_o(dcache_req_addr_o),
    .dcache_req_data_o(dcache_req_data_o), .dcache_req_lsq_index_o(dcache_req_lsq_index_o),
    .dcache_resp_valid_i(dcache_resp_valid_i), .dcache_resp_lsq_index_i(dcache_resp_lsq_index_i),
    .dcache_resp_data_i(dcache_resp_data_i), .dcache_resp_ready_o(dcache_resp_ready_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i)
  );

  typedef struct {
    logic        op;
    logic        sgn;
    logic [1:0]  size;
    logic [38:0] addr;
    logic [63:0] data;
    logic [31:0] rlo;
    logic [31:0] rhi;
    logic        mis;
    logic [38:0] adr0;
    logic [31:0] dat0;
    logic [3:0]  sel;
    logic [31:0] dat1;
    logic        resp;
    logic [63:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [3:0]  idx;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vt[13];
  int   pass_cnt = 0;
  int   total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_exp(input logic [3:0] idx, input logic [63:0] d, input logic e);
    exp_t x;
    x.idx = idx;
    x.data = d;
    x.err = e;
    sb.push_back(x);
  endtask

  // Response monitor: every LSQ response handshake must match the next expected entry
  always @(negedge clk) begin
    if (rstn && lsq_resp_valid_o && lsq_resp_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 64'(lsq_resp_lsq_index_o), 64'hffff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_index", 64'(lsq_resp_lsq_index_o), 64'(e.idx));
        chk("resp_data", lsq_resp_data_o, e.data);
        chk("resp_err", 64'(lsq_resp_err_o), 64'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start(input logic op, input logic [1:0] sz, input logic [38:0] a,
                       input logic [63:0] d, input logic [3:0] idx);
    lsq_req_valid_i = 1'b1;
    lsq_req_opcode_i = op;
    lsq_req_sign_i = 1'b0;
    lsq_req_size_i = sz;
    lsq_req_addr_i = a;
    lsq_req_data_i = d;
    lsq_req_lsq_index_i = idx;
    @(posedge clk); #1;
    lsq_req_valid_i = 1'b0;
  endtask

  task automatic ack_beat(input logic [31:0] d);
    wb_ack_i = 1'b1;
    wb_dat_i = d;
    @(posedge clk); #1;
    wb_ack_i = 1'b0;
  endtask

  task automatic do_vec(input vec_t v, input logic [3:0] idx);
    lsq_req_valid_i = 1'b1;
    lsq_req_opcode_i = v.op;
    lsq_req_sign_i = v.sgn;
    lsq_req_size_i = v.size;
    lsq_req_addr_i = v.addr;
    lsq_req_data_i = v.data;
    lsq_req_lsq_index_i = idx;
    @(negedge clk);
    chk("req_ready", 64'(lsq_req_ready_o), 64'd1);
    chk("dc_req_valid_hit", 64'(dcache_req_valid_o), 64'd0);
    if (v.resp) push_exp(idx, v.rdata, v.err);
    @(posedge clk); #1;
    lsq_req_valid_i = 1'b0;
    if (v.mis) begin
      chk("mis_no_cyc", 64'(wb_cyc_o), 64'd0);
      chk("mis_resp_valid", 64'(lsq_resp_valid_o), 64'd1);
    end else begin
      chk("beat0_cyc", 64'({wb_cyc_o, wb_stb_o}), 64'd3);
      chk("beat0_we", 64'(wb_we_o), 64'(v.op));
      chk("beat0_adr", 64'(wb_adr_o), 64'(v.adr0));
      chk("beat0_sel", 64'(wb_sel_o), 64'(v.sel));
      chk("beat0_dat", 64'(wb_dat_o), 64'(v.dat0));
      ack_beat(v.rlo);
      if (v.size == 2'd3) begin
        chk("beat1_cyc", 64'(wb_cyc_o), 64'd1);
        chk("beat1_adr", 64'(wb_adr_o), 64'(v.adr0 + 39'd4));
        chk("beat1_dat", 64'(wb_dat_o), 64'(v.dat1));
        ack_beat(v.rhi);
      end
      chk("resp_after_ack", 64'(lsq_resp_valid_o), 64'(v.resp));
      chk("cyc_after_ack", 64'(wb_cyc_o), 64'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // op sgn size addr data rlo rhi mis adr0 dat0 sel dat1 resp rdata err
    vt[0]  = '{1'b0, 1'b1, 2'd0, 39'h10000003, 64'h0, 32'h80000000, 32'h0, 1'b0, 39'h10000000,
               32'h0, 4'h8, 32'h0, 1'b1, 64'hFFFFFFFFFFFFFF80, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 2'd0, 39'h10000001, 64'h0, 32'h0000AB00, 32'h0, 1'b0, 39'h10000000,
               32'h0, 4'h2, 32'h0, 1'b1, 64'h00000000000000AB, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 2'd1, 39'h10000002, 64'h0, 32'h80010000, 32'h0, 1'b0, 39'h10000000,
               32'h0, 4'hC, 32'h0, 1'b1, 64'hFFFFFFFFFFFF8001, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 2'd2, 39'h10000004, 64'h0, 32'h80000001, 32'h0, 1'b0, 39'h10000004,
               32'h0, 4'hF, 32'h0, 1'b1, 64'hFFFFFFFF80000001, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 2'd2, 39'h10000008, 64'h0, 32'hDEADBEEF, 32'h0, 1'b0, 39'h10000008,
               32'h0, 4'hF, 32'h0, 1'b1, 64'h00000000DEADBEEF, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 2'd3, 39'h10000010, 64'h0, 32'h55667788, 32'h91223344, 1'b0, 39'h10000010,
               32'h0, 4'hF, 32'h0, 1'b1, 64'h9122334455667788, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 2'd0, 39'h10000002, 64'hA5, 32'h0, 32'h0, 1'b0, 39'h10000000,
               32'h00A50000, 4'h4, 32'h0, 1'b0, 64'h0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 2'd3, 39'h10000008, 64'h1122334455667788, 32'h0, 32'h0, 1'b0, 39'h10000008,
               32'h55667788, 4'hF, 32'h11223344, 1'b0, 64'h0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 2'd1, 39'h10000002, 64'hBEEF, 32'h0, 32'h0, 1'b0, 39'h10000000,
               32'hBEEF0000, 4'hC, 32'h0, 1'b0, 64'h0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 2'd1, 39'h10000001, 64'h0, 32'h0, 32'h0, 1'b1, 39'h0,
               32'h0, 4'h0, 32'h0, 1'b1, 64'h0, 1'b1};
    vt[10] = '{1'b1, 1'b0, 2'd2, 39'h10000006, 64'h12345678, 32'h0, 32'h0, 1'b1, 39'h0,
               32'h0, 4'h0, 32'h0, 1'b1, 64'h0, 1'b1};
    vt[11] = '{1'b0, 1'b0, 2'd3, 39'h10000004, 64'h0, 32'h0, 32'h0, 1'b1, 39'h0,
               32'h0, 4'h0, 32'h0, 1'b1, 64'h0, 1'b1};
    vt[12] = '{1'b0, 1'b0, 2'd0, 39'h40000FFF, 64'h0, 32'h7F000000, 32'h0, 1'b0, 39'h40000FFC,
               32'h0, 4'h8, 32'h0, 1'b1, 64'h000000000000007F, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
    chk("rst_adr", 64'(wb_adr_o), 64'd0);
    chk("rst_dat_sel", 64'({wb_dat_o, wb_sel_o}), 64'd0);
    chk("rst_resp", 64'({lsq_resp_valid_o, lsq_resp_err_o}), 64'd0);
    rstn = 1'b1;
    lsq_resp_ready_i = 1'b1;
    @(posedge clk); #1;

    // Routing of non-window addresses, including both window edges
    lsq_req_valid_i = 1'b1;
    lsq_req_addr_i = 39'h20000000;
    dcache_req_ready_i = 1'b1;
    #1;
    chk("dc_valid_limit", 64'(dcache_req_valid_o), 64'd1);
    chk("dc_ready_pass", 64'(lsq_req_ready_o), 64'd1);
    chk("dc_addr", 64'(dcache_req_addr_o), 64'h20000000);
    dcache_req_ready_i = 1'b0;
    #1;
    chk("dc_ready_low", 64'(lsq_req_ready_o), 64'd0);
    lsq_req_addr_i = 39'h0FFFFFFF;
    #1;
    chk("dc_valid_below", 64'(dcache_req_valid_o), 64'd1);
    lsq_req_addr_i = 39'h10000000;
    #1;
    chk("dc_valid_base", 64'(dcache_req_valid_o), 64'd0);
    chk("bus_ready_idle", 64'(lsq_req_ready_o), 64'd1);
    lsq_req_valid_i = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) do_vec(vt[i], 4'(i));

    // Bus response takes priority over a waiting dcache response
    push_exp(4'd3, 64'h00000000DEADBEEF, 1'b0);
    start(1'b0, 2'd2, 39'h10000008, 64'h0, 4'd3);
    ack_beat(32'hDEADBEEF);
    dcache_resp_valid_i = 1'b1;
    dcache_resp_lsq_index_i = 4'd9;
    dcache_resp_data_i = 64'h1234;
    push_exp(4'd9, 64'h1234, 1'b0);
    #1;
    chk("arb_dc_blocked", 64'(dcache_resp_ready_o), 64'd0);
    chk("arb_bus_first", 64'(lsq_resp_lsq_index_o), 64'd3);
    @(posedge clk); #1;
    chk("arb_dc_ready", 64'(dcache_resp_ready_o), 64'd1);
    chk("arb_dc_next", 64'(lsq_resp_lsq_index_o), 64'd9);
    @(posedge clk); #1;
    dcache_resp_valid_i = 1'b0;

    // Flush during a beat drains the bus cycle without a response
    start(1'b0, 2'd2, 39'h10000000, 64'h0, 4'd4);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("drain_cyc0", 64'(wb_cyc_o), 64'd1);
    chk("drain_ready", 64'(lsq_req_ready_o), 64'd0);
    @(posedge clk); #1;
    chk("drain_cyc1", 64'(wb_cyc_o), 64'd1);
    @(posedge clk); #1;
    ack_beat(32'h5555AAAA);
    chk("drain_done_cyc", 64'(wb_cyc_o), 64'd0);
    chk("drain_no_resp", 64'(lsq_resp_valid_o), 64'd0);
    do_vec(vt[0], 4'd0);

    // Ack and flush together: treated as flush
    start(1'b0, 2'd2, 39'h10000000, 64'h0, 4'd5);
    flush = 1'b1;
    ack_beat(32'h1);
    flush = 1'b0;
    chk("ackflush_cyc", 64'(wb_cyc_o), 64'd0);
    chk("ackflush_no_resp", 64'(lsq_resp_valid_o), 64'd0);

    // Response held under back-pressure, then dropped by flush
    lsq_resp_ready_i = 1'b0;
    start(1'b0, 2'd2, 39'h10000004, 64'h0, 4'd6);
    ack_beat(32'h11);
    chk("hold_valid0", 64'(lsq_resp_valid_o), 64'd1);
    @(posedge clk); #1;
    chk("hold_valid1", 64'(lsq_resp_valid_o), 64'd1);
    chk("hold_data", lsq_resp_data_o, 64'h11);
    chk("hold_index", 64'(lsq_resp_lsq_index_o), 64'd6);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("resp_flushed", 64'(lsq_resp_valid_o), 64'd0);
    lsq_resp_ready_i = 1'b1;

    // Bus error on a store reports an error response
    push_exp(4'd7, 64'h0, 1'b1);
    start(1'b1, 2'd2, 39'h10000000, 64'hCAFE, 4'd7);
    wb_err_i = 1'b1;
    @(posedge clk); #1;
    wb_err_i = 1'b0;
    chk("store_err_resp", 64'(lsq_resp_valid_o), 64'd1);
    @(posedge clk); #1;

    // Reset in the middle of a bus cycle
    start(1'b0, 2'd2, 39'h10000000, 64'h0, 4'd8);
    chk("midrst_cyc_before", 64'(wb_cyc_o), 64'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_cyc", 64'(wb_cyc_o), 64'd0);
    chk("midrst_resp", 64'(lsq_resp_valid_o), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

`ifdef LSU_BUS_TIMEOUT_EN
    push_exp(4'd10, 64'h0, 1'b1);
    start(1'b0, 2'd2, 39'h10000000, 64'h0, 4'd10);
    for (int k = 0; k < 4; k++) begin
      chk("to_cyc_held", 64'(wb_cyc_o), 64'd1);
      @(posedge clk); #1;
    end
    chk("to_cyc_drop", 64'(wb_cyc_o), 64'd0);
    chk("to_resp", 64'(lsq_resp_valid_o), 64'd1);
    @(posedge clk); #1;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/lsu_bus_router.md
# lsu_bus_router

Parametrised load/store router between the LSQ, the dcache and a 32-bit Wishbone master port. It is the second-generation LSU router. Requests whose address falls in one of `N_REGIONS` uncached windows go to a registered Wishbone FSM; all other requests pass combinationally to the dcache. Over the first generation it adds:
- 64-bit accesses split into two bus beats;
- load alignment and sign extension;
- misalignment errors;
- flush-safe draining;
- an optional bus timeout.

## Interface
Parameters:
- `XLEN`, 64, LSQ data width.
- `VIRTUAL_ADDR_LEN`, 39, address width.
- `LSU_LSQ_SIZE_WIDTH`, 4, LSQ index width.
- `WB_DATA_LEN`, 32, bus data width (fixed at 32).
- `N_REGIONS`, 2, number of uncached windows.
- `REGION_BASE`, `{N_REGIONS*VIRTUAL_ADDR_LEN}` packed, inclusive lower bounds.
- `REGION_LIMIT`, `{N_REGIONS*VIRTUAL_ADDR_LEN}` packed, exclusive upper bounds.
- `TIMEOUT_CYCLES`, 255, ack wait limit (used only with the timeout macro).

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `flush` in 1: pipeline flush.
- `lsq_req_valid_i`, `lsq_req_ready_o`, `lsq_req_opcode_i` (0 load / 1 store), `lsq_req_sign_i`, `lsq_req_size_i`[2], `lsq_req_addr_i`[VIRTUAL_ADDR_LEN], `lsq_req_data_i`[XLEN], `lsq_req_lsq_index_i`[LSU_LSQ_SIZE_WIDTH]: LSQ request.
- `lsq_resp_valid_o`, `lsq_resp_ready_i`, `lsq_resp_lsq_index_o`, `lsq_resp_data_o`[XLEN], `lsq_resp_err_o` 1: LSQ response.
- `dcache_req_*` out (same fields as the LSQ request), `dcache_req_ready_i`: dcache request.
- `dcache_resp_valid_i`, `dcache_resp_lsq_index_i`, `dcache_resp_data_i`, `dcache_resp_ready_o`: dcache response.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `wb_adr_o`[VIRTUAL_ADDR_LEN], `wb_dat_o`[32], `wb_sel_o`[4]: Wishbone outputs.
- `wb_ack_i`, `wb_err_i`, `wb_dat_i`[32]: Wishbone inputs.

## Operation
- `hit` = address lies in any window (`BASE <= addr < LIMIT`).
- Routing:
  - `!hit`: `dcache_req_valid_o = lsq_req_valid_i`; `lsq_req_ready_o = dcache_req_ready_i`.
  - `hit`: `lsq_req_ready_o = (state==IDLE)`; `dcache_req_valid_o = 0`.
- FSM states: IDLE, BEAT0, BEAT1, RESP, DRAIN.
- IDLE:
  - On `hit & valid & !flush`, latch the request.
  - Misaligned (size1 with `a[0]`, size2 with `a[1:0]!=0`, size3 with `a[2:0]!=0`) → RESP with `err=1` and data 0, with no bus cycle. This applies to stores too.
  - Otherwise → BEAT0.
- BEAT0 / BEAT1:
  - `cyc = stb = 1`; `we` = opcode.
  - `sel`: size0 `1<<a[1:0]`, size1 `3<<a[1:0]`, size2/3 `4'hf`.
  - `adr`: BEAT0 uses `a & ~3`; BEAT1 uses `a + 4`.
  - `dat`: store data shifted by `a[1:0]*8`; BEAT1 sends `data[63:32]`.
  - `ack`: size3 BEAT0 → BEAT1 and captures the low word. Otherwise, loads → RESP and stores → IDLE (no LSQ response for bus stores).
  - `wb_err_i` → RESP with `err=1`. This applies to loads and stores.
- Load result: `wb_dat_i >> (a[1:0]*8)`, then zero- or sign-extended from 8/16/32 bits per `sign`. Size3 is `{beat1, beat0}`.
- RESP:
  - `lsq_resp_valid_o = 1`, holding index, data and err stable until `lsq_resp_ready_i`.
  - Then → IDLE.
- Response arbitration: RESP has priority. While in RESP, `dcache_resp_ready_o = 0`; otherwise `dcache_resp_ready_o = lsq_resp_ready_i` and the dcache response is passed through with `err=0`.
- Flush:
  - In BEAT0/BEAT1 → DRAIN. DRAIN keeps `cyc`/`stb` until `ack`/`err`, then → IDLE with no response.
  - In RESP → IDLE, response dropped.
  - In IDLE/DRAIN: no effect.
  - The dcache path is unaffected.

## Timing
- Reset: state IDLE. All `wb_*` outputs 0, `lsq_resp_valid_o` 0, `lsq_resp_err_o` 0, all saved registers 0.
- `wb_*` outputs are registered: a request accepted at edge T drives `cyc` from T+1.
- Zero-wait slave: load `lsq_resp_valid_o` in the cycle after `ack` (2 cycles after accept; 3 for size3).
- Misaligned: response 1 cycle after accept.
- `ack` and `flush` in the same cycle: treated as flush, go to IDLE, response dropped.
- Reset mid-transaction: immediately IDLE and `cyc=0`.

## Configuration
- `LSU_BUS_TIMEOUT_EN` defined:
  - An 8+-bit counter clears on entering BEAT0, BEAT1 or DRAIN and increments each cycle without `ack`.
  - Reaching `TIMEOUT_CYCLES` deasserts `cyc`. From BEAT0/BEAT1 → RESP with `err=1` (stores included). From DRAIN → IDLE.
- Undefined: no counter; the FSM waits indefinitely for `ack`/`err`.

## Test plan
- Region 0 byte load at `0x...03` with `sign=1`, `wb_dat_i=0x80_00_00_00`: `sel=4'h8`, response data `0xFFFF_FFFF_FFFF_FF80`, `err=0`.
- Size3 store `0x1122334455667788` at `0x...08`: beat0 `adr=..08`, `dat=0x55667788`; beat1 `adr=..0C`, `dat=0x11223344`; no LSQ response.
- Halfword at `a[0]=1` in a region: no `cyc`; response `err=1` next cycle.
- Bus load in RESP while the dcache response is valid with `lsq_resp_ready_i=1`: bus response first, `dcache_resp_ready_o=0`; dcache response delivered in the next cycle.
- Flush one cycle after accept, with `ack` 3 cycles later: `cyc` held until `ack`, no response; the next request is accepted after returning to IDLE.
- `LSU_BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`, no `ack`: `cyc` drops after 4 cycles; response `err=1`.
